edit_field_controller: RTL and testbench
========================================

Name: edit_field_controller

Overview:
- Front-end control stage that sits directly upstream of the time/date counter-and-BCD bank.
- Converts raw push buttons into the signals that bank consumes: one-hot field enables (STC, MTC, HTC, DF, MF, AF), single-cycle Up/Dw pulses, and the 12/24 h Format level.
- Contains per-button synchronisers, debouncers and edge detectors, plus a field-select state machine.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles needed before a debounced level changes (10 ms at 50 MHz).
- CNT_W, 20: width of each debounce counter; must hold DEBOUNCE_CYCLES-1.
- HOLD_CYCLES, 25000000: auto-repeat initial hold time (AUTOREPEAT_EN only).
- REPEAT_CYCLES, 10000000: auto-repeat period (AUTOREPEAT_EN only).

Ports:
- Clock  in  1  system clock; all state on rising edge
- Reset  in  1  asynchronous, active-high reset
- Btn_Edit  in  1  raw button; enter/leave edit mode
- Btn_Left  in  1  raw button; previous field
- Btn_Right  in  1  raw button; next field
- Btn_Up  in  1  raw button; increment
- Btn_Dw  in  1  raw button; decrement
- Btn_Fmt  in  1  raw button; toggle 12/24 h
- STC  out  1  seconds field enable
- MTC  out  1  minutes field enable
- HTC  out  1  hours field enable
- DF  out  1  day field enable
- MF  out  1  month field enable
- AF  out  1  year field enable
- Up  out  1  one-cycle increment pulse
- Dw  out  1  one-cycle decrement pulse
- Format  out  1  0 = 24 h, 1 = 12 h
- Edit_Mode  out  1  high in any edit state

Behaviour:
- Reset: all outputs 0; FSM in IDLE; synchronisers, debounced levels and counters 0. Reset is asynchronous and applies mid-operation.
- Per-button front end:
  - 2-FF synchroniser.
  - Debounce counter clears on any cycle where synced == debounced level.
  - Otherwise the counter increments. On an edge where synced != debounced level and count == DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - The edge pulse is high during the first cycle the debounced level is 1.
  - Glitches shorter than DEBOUNCE_CYCLES synced cycles produce nothing.
- Latency: with edge 0 the first edge sampling raw high, the debounced level rises after edge DEBOUNCE_CYCLES+1. The registered action/output appears after edge DEBOUNCE_CYCLES+2.
- FSM states: IDLE, E_SEG, E_MIN, E_HR, E_DIA, E_MES, E_ANO.
  - IDLE + Edit pulse -> E_SEG.
  - Any E_* + Edit pulse -> IDLE.
  - Right advances E_SEG -> E_MIN -> E_HR -> E_DIA -> E_MES -> E_ANO -> E_SEG (wraps).
  - Left moves in reverse; E_SEG -> E_ANO (wraps).
  - Left/Right in IDLE are ignored.
- Field enables: registered, one-hot per E_* state (E_SEG = STC ... E_ANO = AF); all 0 in IDLE. Enables are levels held for the whole time the state is occupied.
- Up/Dw pulses:
  - An Up/Dw edge pulse in an E_* state gives exactly one registered cycle of Up/Dw.
  - The field enable stays unchanged in that cycle.
  - Up/Dw edge pulses in IDLE are dropped.
- Simultaneous events, same cycle:
  - Edit beats everything; other pulses in that cycle are dropped.
  - Left and Right together: both ignored.
  - Navigation beats Up/Dw; the adjust is dropped.
  - Up and Dw together: both ignored.
- Format: toggles on each Btn_Fmt pulse, in any state, independent of the FSM.
- Edit_Mode = (state != IDLE), registered.
- Up and Dw are never high together. At most one field enable is high.
- A button held through reset release debounces as a fresh press and produces exactly one pulse.

Optional Feature:
- Macro: EDIT_FIELD_AUTOREPEAT_EN.
- Defined:
  - While debounced Up (or Dw) stays high in an E_* state, an extra pulse is issued HOLD_CYCLES cycles after the initial pulse, then every REPEAT_CYCLES.
  - Release, a state change, or Edit cancels repeating.
  - Repeat pulses obey the same simultaneity rules as press pulses.
- Undefined: repeat counters are absent; exactly one pulse per press.

Test Plan:
- DEBOUNCE_CYCLES=4. Reset, then Btn_Edit high for 20 cycles -> Edit_Mode=1 and STC=1 after edge 6 from first sample; all other enables stay 0.
- In E_SEG, Btn_Up held 20 cycles -> Up high for exactly 1 cycle, STC stays 1, Dw stays 0. Btn_Up 3-cycle glitch -> no pulse.
- Btn_Right pressed 6 times from E_SEG -> enables step MTC, HTC, DF, MF, AF, STC. Btn_Left once from E_SEG -> AF.
- Btn_Up and Btn_Dw pressed together in E_HR -> neither Up nor Dw. Btn_Edit and Btn_Up together -> IDLE, no Up, all enables 0.
- Btn_Fmt pressed twice in IDLE and once in E_MIN -> Format 1, 0, 1. Reset asserted mid-E_DIA -> all outputs 0 immediately, FSM IDLE.
- EDIT_FIELD_AUTOREPEAT_EN, HOLD_CYCLES=10, REPEAT_CYCLES=5: Btn_Dw held 40 cycles in E_MES -> Dw pulses at t0, t0+10, t0+15, t0+20, … while held; none after release.

Source files
------------

// File: rtl/edit_field_controller.sv
`default_nettype none
// ============================================================================
// Module   : edit_field_controller
// Purpose  : Button front end (sync/debounce/edge) and field-select FSM that
//            drives the time/date counter bank; optional auto-repeat is built
//            when EDIT_FIELD_AUTOREPEAT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module edit_field_controller #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 10000000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Btn_Edit,
    input  logic Btn_Left,
    input  logic Btn_Right,
    input  logic Btn_Up,
    input  logic Btn_Dw,
    input  logic Btn_Fmt,
    output logic STC,
    output logic MTC,
    output logic HTC,
    output logic DF,
    output logic MF,
    output logic AF,
    output logic Up,
    output logic Dw,
    output logic Format,
    output logic Edit_Mode
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SEG   = 3'd1;
    localparam logic [2:0] S_MIN   = 3'd2;
    localparam logic [2:0] S_HR    = 3'd3;
    localparam logic [2:0] S_DIA   = 3'd4;
    localparam logic [2:0] S_MES   = 3'd5;
    localparam logic [2:0] S_ANO   = 3'd6;

    logic [5:0] btn_raw;
    logic [5:0] btn_pulse;

    assign btn_raw = {Btn_Fmt, Btn_Dw, Btn_Up, Btn_Right, Btn_Left, Btn_Edit};

    for (genvar i = 0; i < 6; i++) begin : g_btn
        logic             sync1_q;
        logic             sync2_q;
        logic             level_q;
        logic             level_d;
        logic             level_prev_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] cnt_d;

        // Counter runs only while the synced input disagrees with the level.
        always_comb begin
            level_d = level_q;
            cnt_d   = '0;
            if (sync2_q != level_q) begin
                if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    level_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end

        always_ff @(posedge Clock or posedge Reset) begin
            if (Reset) begin
                sync1_q      <= 1'b0;
                sync2_q      <= 1'b0;
                level_q      <= 1'b0;
                level_prev_q <= 1'b0;
                cnt_q        <= '0;
            end else begin
                sync1_q      <= btn_raw[i];
                sync2_q      <= sync1_q;
                level_q      <= level_d;
                level_prev_q <= level_q;
                cnt_q        <= cnt_d;
            end
        end

        assign btn_pulse[i] = level_q & ~level_prev_q;
    end

    logic edit_p, left_p, right_p, up_p, dw_p, fmt_p;
    assign edit_p  = btn_pulse[0];
    assign left_p  = btn_pulse[1];
    assign right_p = btn_pulse[2];
    assign up_p    = btn_pulse[3];
    assign dw_p    = btn_pulse[4];
    assign fmt_p   = btn_pulse[5];

    logic [2:0] state_q, state_d;
    logic [5:0] field_en_q, field_en_d;
    logic       up_q, up_d, dw_q, dw_d;
    logic       fmt_q, fmt_d;
    logic       edit_mode_q, edit_mode_d;
    logic       up_req, dw_req;
    logic       adj_ok;

`ifdef EDIT_FIELD_AUTOREPEAT_EN
    localparam int RPT_W = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES
                                                                 : REPEAT_CYCLES) + 1;

    logic             up_level, dw_level;
    logic             rpt_act_q, rpt_act_d;
    logic             rpt_up_q, rpt_up_d;
    logic             rpt_first_q, rpt_first_d;
    logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_hit, rpt_fire;

    assign up_level = g_btn[3].level_q;
    assign dw_level = g_btn[4].level_q;

    // Count is zero in the cycle the last pulse was visible on Up/Dw.
    assign rpt_hit  = rpt_first_q ? (rpt_cnt_q == RPT_W'(HOLD_CYCLES - 1))
                                  : (rpt_cnt_q == RPT_W'(REPEAT_CYCLES - 1));
    assign rpt_fire = rpt_act_q & rpt_hit & (rpt_up_q ? up_level : dw_level);
    assign up_req   = up_p | (rpt_fire & rpt_up_q);
    assign dw_req   = dw_p | (rpt_fire & ~rpt_up_q);

    always_comb begin
        rpt_act_d   = rpt_act_q;
        rpt_up_d    = rpt_up_q;
        rpt_first_d = rpt_first_q;
        rpt_cnt_d   = rpt_act_q ? rpt_cnt_q + 1'b1 : '0;
        if (up_d | dw_d) begin
            rpt_act_d   = 1'b1;
            rpt_up_d    = up_d;
            rpt_first_d = up_p | dw_p;
            rpt_cnt_d   = '0;
        end else if (edit_p || (state_d != state_q) ||
                     !(rpt_up_q ? up_level : dw_level)) begin
            rpt_act_d = 1'b0;
            rpt_cnt_d = '0;
        end else if (rpt_fire) begin
            rpt_first_d = 1'b0;
            rpt_cnt_d   = '0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rpt_act_q   <= 1'b0;
            rpt_up_q    <= 1'b0;
            rpt_first_q <= 1'b0;
            rpt_cnt_q   <= '0;
        end else begin
            rpt_act_q   <= rpt_act_d;
            rpt_up_q    <= rpt_up_d;
            rpt_first_q <= rpt_first_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end
`else
    assign up_req = up_p;
    assign dw_req = dw_p;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q     <= S_IDLE;
            field_en_q  <= '0;
            up_q        <= 1'b0;
            dw_q        <= 1'b0;
            fmt_q       <= 1'b0;
            edit_mode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_en_q  <= field_en_d;
            up_q        <= up_d;
            dw_q        <= dw_d;
            fmt_q       <= fmt_d;
            edit_mode_q <= edit_mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (edit_p) begin
            state_d = (state_q == S_IDLE) ? S_SEG : S_IDLE;
        end else if ((state_q != S_IDLE) && (right_p ^ left_p)) begin
            if (right_p) begin
                state_d = (state_q == S_ANO) ? S_SEG : state_q + 3'd1;
            end else begin
                state_d = (state_q == S_SEG) ? S_ANO : state_q - 3'd1;
            end
        end
    end

    // Adjust only in an edit state, with no Edit or navigation in the same cycle.
    assign adj_ok = (state_q != S_IDLE) & ~edit_p & ~(left_p | right_p) & (up_req ^ dw_req);

    always_comb begin
        field_en_d = '0;
        case (state_d)
            S_SEG:   field_en_d = 6'b000001;
            S_MIN:   field_en_d = 6'b000010;
            S_HR:    field_en_d = 6'b000100;
            S_DIA:   field_en_d = 6'b001000;
            S_MES:   field_en_d = 6'b010000;
            S_ANO:   field_en_d = 6'b100000;
            default: field_en_d = '0;
        endcase
        up_d        = adj_ok & up_req;
        dw_d        = adj_ok & dw_req;
        fmt_d       = fmt_q ^ fmt_p;
        edit_mode_d = (state_d != S_IDLE);
    end

    assign STC       = field_en_q[0];
    assign MTC       = field_en_q[1];
    assign HTC       = field_en_q[2];
    assign DF        = field_en_q[3];
    assign MF        = field_en_q[4];
    assign AF        = field_en_q[5];
    assign Up        = up_q;
    assign Dw        = dw_q;
    assign Format    = fmt_q;
    assign Edit_Mode = edit_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_edit_field_controller.sv
`default_nettype none
// Directed bench for edit_field_controller with DEBOUNCE_CYCLES=4; outputs are
// compared against a queue of expected snapshots {Edit_Mode,Format,Dw,Up,AF..STC}.
module tb_edit_field_controller;

    localparam logic [5:0] B_EDIT  = 6'b000001;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000100;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DW    = 6'b010000;
    localparam logic [5:0] B_FMT   = 6'b100000;

    localparam logic [5:0] E_STC = 6'b000001;
    localparam logic [5:0] E_MTC = 6'b000010;
    localparam logic [5:0] E_HTC = 6'b000100;
    localparam logic [5:0] E_DF  = 6'b001000;
    localparam logic [5:0] E_MF  = 6'b010000;
    localparam logic [5:0] E_AF  = 6'b100000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] btn = '0;
    logic       STC, MTC, HTC, DF, MF, AF, Up, Dw, Format, Edit_Mode;
    logic [9:0] outv;

    int n_cmp  = 0;
    int n_fail = 0;
    int up_cnt = 0;
    int dw_cnt = 0;

    logic [9:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    edit_field_controller #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .HOLD_CYCLES    (10),
        .REPEAT_CYCLES  (5)
    ) dut (
        .Clock    (clk),
        .Reset    (rst),
        .Btn_Edit (btn[0]),
        .Btn_Left (btn[1]),
        .Btn_Right(btn[2]),
        .Btn_Up   (btn[3]),
        .Btn_Dw   (btn[4]),
        .Btn_Fmt  (btn[5]),
        .STC      (STC),
        .MTC      (MTC),
        .HTC      (HTC),
        .DF       (DF),
        .MF       (MF),
        .AF       (AF),
        .Up       (Up),
        .Dw       (Dw),
        .Format   (Format),
        .Edit_Mode(Edit_Mode)
    );

    assign outv = {Edit_Mode, Format, Dw, Up, AF, MF, DF, HTC, MTC, STC};

    always @(posedge clk) begin
        #1;
        if (Up) up_cnt++;
        if (Dw) dw_cnt++;
        n_cmp++;
        assert (!(Up && Dw) && ($countones({AF, MF, DF, HTC, MTC, STC}) <= 1)) else begin
            n_fail++;
            $error("FAIL invariant: observed %b expected at most one enable and not Up&Dw", outv);
        end
    end

    function automatic logic [9:0] vec(input logic em, input logic fmt, input logic dw,
                                       input logic up, input logic [5:0] en);
        return {em, fmt, dw, up, en};
    endfunction

    task automatic adv(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input string t, input logic [9:0] v);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic sb_check();
        logic [9:0] e;
        string      t;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty: observed %b expected a queued entry", outv);
        end else begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            assert (outv === e) else begin
                n_fail++;
                $error("FAIL %s: observed %b expected %b", t, outv, e);
            end
        end
    endtask

    task automatic check_val(input string t, input int got, input int want);
        n_cmp++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", t, got, want);
        end
    endtask

    // Press buttons in mask for hold cycles; compare outputs right after edge 6.
    task automatic press(input logic [5:0] mask, input int hold,
                         input logic [9:0] v, input string t);
        sb_push(t, v);
        btn = mask;
        adv(7);
        sb_check();
        adv(hold - 7);
        btn = '0;
        adv(12);
    endtask

    function automatic logic exp_dw(input int k);
`ifdef EDIT_FIELD_AUTOREPEAT_EN
        return (k == 6) || (k >= 16 && k <= 41 && ((k - 16) % 5) == 0);
`else
        return (k == 6);
`endif
    endfunction

    initial begin
        int         up0;
        int         dw0;
        int         up_expect;
        logic [5:0] seq [6];
        seq = '{E_MTC, E_HTC, E_DF, E_MF, E_AF, E_STC};
`ifdef EDIT_FIELD_AUTOREPEAT_EN
        up_expect = 3;
`else
        up_expect = 1;
`endif

        // Reset state
        adv(3);
        sb_push("reset_held", '0);
        sb_check();
        rst = 1'b0;
        adv(2);
        sb_push("reset_released", '0);
        sb_check();

        // Enter edit mode: nothing after edge 5, E_SEG after edge 6
        sb_push("edit_edge5", '0);
        sb_push("edit_edge6", vec(1, 0, 0, 0, E_STC));
        btn = B_EDIT;
        adv(6);
        sb_check();
        adv(1);
        sb_check();
        adv(13);
        btn = '0;
        adv(12);
        sb_push("edit_stays", vec(1, 0, 0, 0, E_STC));
        sb_check();

        // Up held 20 cycles, then a 3-cycle glitch
        up0 = up_cnt;
        press(B_UP, 20, vec(1, 0, 0, 1, E_STC), "up_pulse");
        sb_push("up_after", vec(1, 0, 0, 0, E_STC));
        sb_check();
        check_val("up_count", up_cnt - up0, up_expect);
        check_val("dw_count", dw_cnt, 0);
        up0 = up_cnt;
        btn = B_UP;
        adv(3);
        btn = '0;
        adv(15);
        check_val("glitch_up_count", up_cnt - up0, 0);
        sb_push("glitch_state", vec(1, 0, 0, 0, E_STC));
        sb_check();

        // Navigation right with wrap, then left wrap
        for (int i = 0; i < 6; i++) press(B_RIGHT, 8, vec(1, 0, 0, 0, seq[i]), "right_step");
        press(B_LEFT, 8, vec(1, 0, 0, 0, E_AF), "left_wrap");

        // Up and Dw together in E_HR
        press(B_RIGHT, 8, vec(1, 0, 0, 0, E_STC), "to_seg");
        press(B_RIGHT, 8, vec(1, 0, 0, 0, E_MTC), "to_min");
        press(B_RIGHT, 8, vec(1, 0, 0, 0, E_HTC), "to_hr");
        up0 = up_cnt;
        dw0 = dw_cnt;
        press(B_UP | B_DW, 8, vec(1, 0, 0, 0, E_HTC), "up_dw_both");
        check_val("both_up_count", up_cnt - up0, 0);
        check_val("both_dw_count", dw_cnt - dw0, 0);

        // Edit beats Up
        press(B_EDIT | B_UP, 8, vec(0, 0, 0, 0, '0), "edit_beats_up");
        check_val("edit_up_count", up_cnt - up0, 0);

        // Format toggles in IDLE and in edit mode
        press(B_FMT, 8, vec(0, 1, 0, 0, '0), "fmt_idle_1");
        press(B_FMT, 8, vec(0, 0, 0, 0, '0), "fmt_idle_2");
        press(B_EDIT, 8, vec(1, 0, 0, 0, E_STC), "reenter");
        press(B_RIGHT, 8, vec(1, 0, 0, 0, E_MTC), "to_min2");
        press(B_FMT, 8, vec(1, 1, 0, 0, E_MTC), "fmt_min");

        // Asynchronous reset in E_DIA
        press(B_RIGHT, 8, vec(1, 1, 0, 0, E_HTC), "to_hr2");
        press(B_RIGHT, 8, vec(1, 1, 0, 0, E_DF), "to_dia");
        sb_push("reset_async", '0);
        rst = 1'b1;
        #1;
        sb_check();
        adv(2);
        rst = 1'b0;
        adv(2);
        sb_push("reset_after", '0);
        sb_check();

        // Edit held through reset release is a fresh press
        btn = B_EDIT;
        rst = 1'b1;
        adv(3);
        rst = 1'b0;
        sb_push("held_thru_reset", vec(1, 0, 0, 0, E_STC));
        adv(7);
        sb_check();
        adv(6);
        btn = '0;
        adv(12);
        sb_push("held_single", vec(1, 0, 0, 0, E_STC));
        sb_check();

        // Dw held 40 cycles in E_MES
        press(B_LEFT, 8, vec(1, 0, 0, 0, E_AF), "to_ano");
        press(B_LEFT, 8, vec(1, 0, 0, 0, E_MF), "to_mes");
        btn = B_DW;
        for (int k = 0; k < 56; k++) begin
            sb_push("dw_hold", vec(1, 0, exp_dw(k), 0, E_MF));
            adv(1);
            sb_check();
            if (k == 39) btn = '0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
